// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB PID constants, tx state enum and CRC16 parameters
// Ports: none (package). Imported by the tx engine and the CRC16 byte helper.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_PID,
        TX_DATA,
        TX_CRC_LO,
        TX_CRC_HI,
        TX_GAP
    } tx_state_e;

    // Only data PIDs carry a payload and a CRC16.
    function automatic logic pid_is_data(input logic [3:0] pid);
        logic r;
        case (pid)
            PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// rtl/usb_crc16_byte.sv - combinational USB CRC16 update over one byte, LSB first
// Ports: crc_in[15:0] running CRC, data_in[7:0] byte, crc_out[15:0] updated CRC.
module usb_crc16_byte
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Reflected shift register: bit 0 is the oldest bit, so each step shifts
    // right and folds the polynomial in when the feedback bit is set.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_in[i]) begin
                c = (c >> 1) ^ CRC16_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb_utmi_tx_engine.sv
// rtl/usb_utmi_tx_engine.sv - UTMI transmit packet engine: PID, payload, CRC16
// Ports: clock/reset (async, active high); req_* packet request handshake;
// pl_* upstream payload stream; utmi_* PHY transmit pins; done/underrun pulses.
module usb_utmi_tx_engine
    import usb_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_pid,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic [7:0]       utmi_data_out,
    output logic             utmi_txvalid,
    input  logic             utmi_txready,
    output logic             done,
    output logic             underrun
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    tx_state_e        state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       data_q, data_d;
    logic             txvalid_q, txvalid_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic [15:0]      crc_next;
    logic             is_data;
    logic             byte_due;

    usb_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data_in (pl_data),
        .crc_out (crc_next)
    );

    assign is_data  = pid_is_data(pid_q);
    assign byte_due = ((state_q == TX_PID) && is_data && (len_q != '0)) ||
                      ((state_q == TX_DATA) && (cnt_q < len_q));

    // pl_ready commits to consuming the byte, so it only rises on cycles
    // where the PHY takes the current byte and the next one is owed.
    assign pl_ready      = utmi_txready && byte_due;
    assign req_ready     = (state_q == TX_IDLE);
    assign utmi_data_out = data_q;
    assign utmi_txvalid  = txvalid_q;
    assign done          = done_q;
    assign underrun      = underrun_q;

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        data_d     = data_q;
        txvalid_d  = txvalid_q;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (req_valid) begin
                    pid_d     = req_pid;
                    len_d     = (req_len > LEN_MAX) ? LEN_MAX : req_len;
                    data_d    = {~req_pid, req_pid};
                    txvalid_d = 1'b1;
                    crc_d     = CRC16_INIT;
                    cnt_d     = '0;
                    state_d   = TX_PID;
                end
            end
            TX_PID, TX_DATA: begin
                if (utmi_txready) begin
                    if ((state_q == TX_PID) && !is_data) begin
                        txvalid_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = TX_GAP;
                    end else if (byte_due) begin
                        if (pl_valid) begin
                            data_d  = pl_data;
                            crc_d   = crc_next;
                            cnt_d   = cnt_q + 1'b1;
                            state_d = TX_DATA;
                        end else begin
                            // Missing payload: abort without CRC so the
                            // receiver sees a bad packet rather than a short one.
                            txvalid_d  = 1'b0;
                            underrun_d = 1'b1;
                            state_d    = TX_GAP;
                        end
                    end else begin
                        data_d  = ~crc_q[7:0];
                        state_d = TX_CRC_LO;
                    end
                end
            end
            TX_CRC_LO: begin
                if (utmi_txready) begin
                    data_d  = ~crc_q[15:8];
                    state_d = TX_CRC_HI;
                end
            end
            TX_CRC_HI: begin
                if (utmi_txready) begin
                    txvalid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = TX_GAP;
                end
            end
            TX_GAP: begin
                state_d = TX_IDLE;
            end
            default: begin
                txvalid_d = 1'b0;
                state_d   = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            pid_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            crc_q      <= CRC16_INIT;
            data_q     <= 8'h00;
            txvalid_q  <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            data_q     <= data_d;
            txvalid_q  <= txvalid_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: doc/usb_utmi_tx_engine.md
# usb_utmi_tx_engine

Device-side UTMI transmit packet engine for the Microwatt USB peripheral: it turns a packet request into the 8-bit UTMI transmit byte stream. It covers the PID byte, the payload streamed from an upstream buffer, and the CRC16. It is the transmit counterpart of the UTMI receive path driven by the USB bench (rxvalid/rxactive/data_in), and it sits between the endpoint buffer logic and the UTMI PHY pins (utmi_data_out/txvalid/txready).

## Interface
- MAX_LEN, 64: maximum payload bytes per data packet.
- LEN_W, $clog2(MAX_LEN+1): width of the length field.

- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  packet request strobe.
- req_ready  out  1  engine is idle and able to accept a request.
- req_pid  in  4  PID[3:0]; the byte on the wire is {~pid, pid}.
- req_len  in  LEN_W  payload byte count; only used for data PIDs.
- pl_data  in  8  payload byte.
- pl_valid  in  1  payload byte available.
- pl_ready  out  1  payload byte consumed this cycle.
- utmi_data_out  out  8  transmit byte (registered).
- utmi_txvalid  out  1  transmit valid (registered).
- utmi_txready  in  1  PHY accepted the current byte.
- done  out  1  one-cycle pulse when a packet completes normally.
- underrun  out  1  one-cycle pulse when a packet is aborted because the payload was missing.

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP.
- **Data PIDs** are DATA0 (0x3), DATA1 (0xB), DATA2 (0x7) and MDATA (0xF). They are sent as PID, then payload, then CRC16.
- **All other PIDs** (ACK 0x2, NAK 0xA, STALL 0xE, NYET 0x6, and others) are sent as PID only; req_len is ignored.
- **IDLE:** req_ready=1. On req_valid:
  - latch pid and min(req_len, MAX_LEN);
  - set utmi_data_out={~pid,pid} and utmi_txvalid=1;
  - set crc=16'hFFFF and cnt=0;
  - go to PID.
- **PID**, on utmi_txready:
  - non-data PID: txvalid=0, done=1, go to GAP;
  - data PID with len=0: data_out=~crc[7:0], go to CRC_LO;
  - data PID with len>0: take a payload byte (see load rule), go to DATA.
- **Load rule.** Asserting pl_ready is a commitment to consume the byte in that cycle.
  - pl_ready=utmi_txready && a payload byte is due. A byte is due in PID when len>0, and in DATA when cnt<len.
  - If pl_valid=1: data_out=pl_data, crc=crc16_upd(crc,pl_data), cnt=cnt+1.
  - If pl_valid=0: underrun. txvalid=0, underrun=1, go to GAP; no CRC is sent.
- **DATA**, on utmi_txready:
  - cnt<len: apply the load rule;
  - cnt==len: data_out=~crc[7:0], go to CRC_LO.
- **CRC_LO**, on utmi_txready: data_out=~crc[15:8], go to CRC_HI.
- **CRC_HI**, on utmi_txready: txvalid=0, done=1, go to GAP.
- **GAP:** one cycle with txvalid low, then go to IDLE. This guarantees txvalid is deasserted between packets.
- **Holding rule:** while utmi_txready=0, utmi_data_out, the state and the CRC hold.
- **CRC16 (USB):**
  - reflected polynomial 0xA001 (0x8005 LSB-first), init 0xFFFF;
  - updated with the payload bytes only, LSB-first;
  - transmitted inverted, low byte first.
- **Upstream contract:** after req accept, pl_valid must deliver len bytes on consecutive txready cycles. Pre-fill the buffer before issuing a request.

## Timing
- Reset values:
  - state=IDLE;
  - utmi_txvalid=0, utmi_data_out=8'h00;
  - done=0, underrun=0;
  - req_ready=1, pl_ready=0.
- Reset asserted mid-packet drops txvalid immediately (asynchronously), without a CRC or done pulse.
- Timeline with request accepted at edge 0 and txready held high, for N payload bytes:
  - PID on the bus in cycle 1;
  - payload in cycles 2..N+1;
  - CRC in cycles N+2 and N+3;
  - txvalid low and done in cycle N+4;
  - req_ready high in cycle N+5.
- Handshake-only packet: PID in cycle 1, done in cycle 2, req_ready in cycle 3.
- req_valid is ignored outside IDLE.
- req_len>MAX_LEN saturates to MAX_LEN.
- done and underrun are mutually exclusive and registered.

## Structure
- Shared package usb_pkg holds:
  - PID constants (PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL, …);
  - the tx state enum;
  - CRC16_INIT=16'hFFFF and CRC16_POLY_REFL=16'hA001.
- Sub-module usb_crc16_byte: combinational 8-step reflected CRC16 update, 16-bit crc_in plus 8-bit data in, 16-bit crc_out. The receive path reuses it.

## Test plan
- **ACK:** pid=0x2, txready=1 -> one byte 0xD2 with txvalid high for 1 cycle, then done; pl_ready never asserted.
- **Zero-length DATA1:** pid=0xB, len=0 -> bytes 0x4B, 0x00, 0x00, then done.
- **DATA0 payload:** pid=0x3, len=8, payload 0x11..0x88 -> 0xC3, the 8 bytes, then 2 CRC bytes matching the bench model. Re-running the CRC over payload+CRC bytes gives residual 0xB001.
- **Backpressure:** txready toggled randomly (about 50%) during the DATA0 test -> identical byte sequence, each byte held until txready, and pl_ready only on txready cycles.
- **Underrun:** len=4, pl_valid dropped before the 3rd byte -> txvalid falls, underrun pulses once, no CRC bytes, IDLE two cycles later.
- **Reset mid-packet and saturation:**
  - reset asserted during DATA -> txvalid=0 asynchronously and req_ready=1 after release;
  - a following NAK request -> 0x5A;
  - len=MAX_LEN+5 -> exactly MAX_LEN payload bytes.
